// File: rtl/gate_input_debouncer.sv
// Two-channel switch debouncer feeding the logic-gate module's I1/I2 inputs.
// Each raw switch is synchronised with two flops. A new level is then committed
// to the output only after it has held for STABLE_COUNT synchronised cycles.
// The output flop toggles on commit and a one-cycle change pulse is registered.

// Single debounce channel: synchroniser, 1-bit FSM, stability counter.
//
// state   | meaning
// --------+----------------------------------------------------------------
// STABLE  | synchronised input equals committed output, counter held at 0
// PENDING | synchronised input differs from output, counting stable cycles
module gate_input_debouncer_ch #(
  parameter int unsigned STABLE_COUNT = 50000,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw_raw,
  output logic db,
  output logic chg,
  output logic commit
);

  localparam logic [0:0] STABLE  = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  // Terminal count: the cycle on which the pending level has persisted long enough.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(STABLE_COUNT - 1);

  logic                 s1;
  logic                 s2;
  logic [0:0]           state;
  logic [0:0]           state_nxt;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_nxt;

  // Two-flop synchroniser; only s2 is allowed to reach the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= sw_raw;
      s2 <= s1;
    end
  end

  // Next-state, counter and commit decode.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    commit    = 1'b0;
    case (state)
      STABLE: begin
        cnt_nxt = CNT_ZERO;
        if (s2 != db) begin
          // A one-cycle stability window means the first differing sample commits.
          if (STABLE_COUNT == 1) begin
            commit = 1'b1;
          end else begin
            state_nxt = PENDING;
            cnt_nxt   = CNT_ONE;
          end
        end
      end
      PENDING: begin
        if (s2 == db) begin
          // Bounced back to the committed level: abandon the pending change.
          state_nxt = STABLE;
          cnt_nxt   = CNT_ZERO;
        end else if (cnt == CNT_LAST) begin
          commit    = 1'b1;
          state_nxt = STABLE;
          cnt_nxt   = CNT_ZERO;
        end else begin
          cnt_nxt = cnt + CNT_ONE;
        end
      end
      default: begin
        state_nxt = STABLE;
        cnt_nxt   = CNT_ZERO;
      end
    endcase
  end

  // State, counter, committed level and change pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= STABLE;
      cnt   <= CNT_ZERO;
      db    <= 1'b0;
      chg   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      chg   <= commit;
      if (commit) begin
        db <= s2;
      end
    end
  end

endmodule

// Top: two independent channels plus the registered combined change pulse.
module gate_input_debouncer #(
  parameter int unsigned STABLE_COUNT = 50000,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw1_raw,
  input  logic sw2_raw,
  output logic i1_db,
  output logic i2_db,
  output logic i1_chg,
  output logic i2_chg,
  output logic any_chg
);

  logic i1_commit;
  logic i2_commit;

  gate_input_debouncer_ch #(
    .STABLE_COUNT(STABLE_COUNT),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_ch1 (
    .clk   (clk),
    .rst_n (rst_n),
    .sw_raw(sw1_raw),
    .db    (i1_db),
    .chg   (i1_chg),
    .commit(i1_commit)
  );

  gate_input_debouncer_ch #(
    .STABLE_COUNT(STABLE_COUNT),
    .CNT_WIDTH   (CNT_WIDTH)
  ) u_ch2 (
    .clk   (clk),
    .rst_n (rst_n),
    .sw_raw(sw2_raw),
    .db    (i2_db),
    .chg   (i2_chg),
    .commit(i2_commit)
  );

  // Combined pulse registered on the same edge as the per-channel pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      any_chg <= 1'b0;
    end else begin
      any_chg <= i1_commit | i2_commit;
    end
  end

endmodule

// File: tb/tb_gate_input_debouncer.sv
// Directed bench for gate_input_debouncer with STABLE_COUNT = 4.
// Inputs are driven 1 time unit after a rising edge, so the next edge is E0.
// A committed level therefore appears after edge E0+5, with its pulse during that cycle.
module tb_gate_input_debouncer;

  localparam int SC = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic sw1_raw = 1'b0;
  logic sw2_raw = 1'b0;
  logic i1_db, i2_db, i1_chg, i2_chg, any_chg;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic sw1;
    logic sw2;
    logic e_i1;
    logic e_i2;
    logic e_c1;
    logic e_c2;
    logic e_any;
    string tag;
  } vec_t;

  vec_t vecs[$];

  gate_input_debouncer #(
    .STABLE_COUNT(SC),
    .CNT_WIDTH   (16)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .sw1_raw(sw1_raw),
    .sw2_raw(sw2_raw),
    .i1_db  (i1_db),
    .i2_db  (i2_db),
    .i1_chg (i1_chg),
    .i2_chg (i2_chg),
    .any_chg(any_chg)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all(input string tag, input logic e1, input logic e2,
                           input logic c1, input logic c2, input logic ca);
    check({tag, ".i1_db"},   i1_db,   e1);
    check({tag, ".i2_db"},   i2_db,   e2);
    check({tag, ".i1_chg"},  i1_chg,  c1);
    check({tag, ".i2_chg"},  i2_chg,  c2);
    check({tag, ".any_chg"}, any_chg, ca);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add_row(input string tag, input logic s1, input logic s2,
                         input logic e1, input logic e2, input logic c1,
                         input logic c2, input logic ca);
    vecs.push_back('{s1, s2, e1, e2, c1, c2, ca, tag});
  endtask

  // Hold inputs for n rows; outputs go from (b1,b2) to (a1,a2) at row crow.
  task automatic add_hold(input string tag, input int n, input logic s1, input logic s2,
                          input logic b1, input logic b2, input logic a1, input logic a2,
                          input int crow);
    for (int r = 0; r < n; r++) begin
      if (r < crow)
        add_row(tag, s1, s2, b1, b2, 1'b0, 1'b0, 1'b0);
      else if (r == crow)
        add_row(tag, s1, s2, a1, a2, a1 ^ b1, a2 ^ b2, (a1 ^ b1) | (a2 ^ b2));
      else
        add_row(tag, s1, s2, a1, a2, 1'b0, 1'b0, 1'b0);
    end
  endtask

  initial begin
    // Vector table; starts from i1_db=i2_db=1 with raw inputs high.
    add_hold("both_fall", 7, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 5);
    add_hold("clean_rise1", 7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 5);
    add_hold("clean_fall1", 7, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 5);
    add_row("bounce1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_row("bounce1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_row("bounce1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_row("bounce1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_row("bounce1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_row("bounce1", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_row("bounce1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_row("bounce1", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_hold("bounce1_settle", 4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 99);
    add_row("bounce2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_row("bounce2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_row("bounce2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_row("bounce2", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    add_hold("bounce2_settle", 7, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5);
    add_hold("clean_fall2", 7, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5);
    add_hold("simul_rise", 7, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5);

    // Reset held with inputs high: everything stays zero.
    rst_n   = 1'b0;
    sw1_raw = 1'b1;
    sw2_raw = 1'b1;
    #1;
    check_all("rst_async0", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("rst_hold", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b1;
    // First edge after release is E0; commit after edge E0+5 (n == 6).
    for (int n = 1; n <= 8; n++) begin
      step();
      check_all($sformatf("rst_rel_e%0d", n), n >= 6, n >= 6, n == 6, n == 6, n == 6);
    end

    foreach (vecs[k]) begin
      sw1_raw = vecs[k].sw1;
      sw2_raw = vecs[k].sw2;
      step();
      check_all($sformatf("%s_r%0d", vecs[k].tag, k), vecs[k].e_i1, vecs[k].e_i2,
                vecs[k].e_c1, vecs[k].e_c2, vecs[k].e_any);
    end

    // Asynchronous reset assertion clears committed outputs without a clock edge.
    #2;
    rst_n = 1'b0;
    #1;
    check_all("async_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    sw1_raw = 1'b0;
    sw2_raw = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("idle_low", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end

    // Reset mid-count: sw1 rises, reset hits after 3 edges, pending change is lost.
    sw1_raw = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check_all("midcnt_pre", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    rst_n = 1'b0;
    step();
    check_all("midcnt_rst", 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int n = 1; n <= 7; n++) begin
      step();
      check_all($sformatf("midcnt_rel_e%0d", n), n >= 6, 1'b0, n == 6, 1'b0, n == 6);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
